// File: rtl/lstm_x_feeder_if.sv
// Host-write / lstm_unit stream bundle for lstm_x_feeder.
interface lstm_x_feeder_if #(
  parameter int DATA_W = 10,
  parameter int STEP_W = 16
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              overflow;
  logic              start;
  logic [STEP_W-1:0] num_steps;
  logic              step_done;
  logic              load;
  logic [DATA_W-1:0] x_out;
  logic              busy;
  logic              seq_done;
  logic [STEP_W-1:0] step_cnt;

  modport master (
    output wr_en, wr_data, start, num_steps, step_done,
    input  full, overflow, load, x_out, busy, seq_done, step_cnt
  );

  modport slave (
    input  wr_en, wr_data, start, num_steps, step_done,
    output full, overflow, load, x_out, busy, seq_done, step_cnt
  );
endinterface

// File: rtl/lstm_x_feeder.sv
// Buffers host samples and feeds one BURST_LEN-sample burst per time step into
// the first lstm_unit, waiting for its output_done between steps.
module lstm_x_feeder #(
  parameter int DATA_W    = 10,
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 64,
  parameter int STEP_W    = 16
) (
  input logic            clk,
  input logic            reset,
  lstm_x_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, BURST, WAIT_ACK, DONE} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full_i, wr_acc, rd_en;
  logic [BW-1:0]     beat;
  logic              step_done_q;
  logic [STEP_W-1:0] num_steps_q, step_cnt_q, step_cnt_inc;
  logic              latch, ack;
  logic              load_q, busy_q, seq_done_q, ovf_q;
  logic [DATA_W-1:0] x_q;

  assign full_i       = (count == (AW+1)'(DEPTH));
  assign wr_acc       = bus.wr_en && !full_i;
  assign step_cnt_inc = step_cnt_q + STEP_W'(1);

  assign bus.full     = full_i;
  assign bus.overflow = ovf_q;
  assign bus.load     = load_q;
  assign bus.x_out    = x_q;
  assign bus.busy     = busy_q;
  assign bus.seq_done = seq_done_q;
  assign bus.step_cnt = step_cnt_q;

  // Sample storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  // Circular-buffer pointers and occupancy; write and read may coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && full_i) ovf_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; the burst reads one sample per cycle until beat hits BURST_LEN.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    latch   = 1'b0;
    ack     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch   = 1'b1;
          state_n = (bus.num_steps == '0) ? DONE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (count >= (AW+1)'(BURST_LEN)) state_n = BURST;
      end
      BURST: begin
        if (beat == BW'(BURST_LEN)) state_n = WAIT_ACK;
        else                        rd_en   = 1'b1;
      end
      WAIT_ACK: begin
        // Only a rising edge seen while waiting counts, so a level left over
        // from the burst is not mistaken for an acknowledge.
        if (bus.step_done && !step_done_q) begin
          ack     = 1'b1;
          state_n = (step_cnt_inc == num_steps_q) ? DONE : WAIT_DATA;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs, step bookkeeping and step_done edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q      <= 1'b0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      step_cnt_q  <= '0;
      num_steps_q <= '0;
      beat        <= '0;
      step_done_q <= 1'b0;
    end else begin
      load_q      <= rd_en;
      x_q         <= rd_en ? mem[rd_ptr] : '0;
      busy_q      <= (state_n == WAIT_DATA) || (state_n == BURST) || (state_n == WAIT_ACK);
      seq_done_q  <= (state_n == DONE);
      beat        <= rd_en ? beat + BW'(1) : '0;
      step_done_q <= bus.step_done;
      if (latch) begin
        step_cnt_q  <= '0;
        num_steps_q <= bus.num_steps;
      end else if (ack) begin
        step_cnt_q  <= step_cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_lstm_x_feeder.sv
// Randomized bench for lstm_x_feeder against a queue-based model of the sample stream.
module tb_lstm_x_feeder;
  localparam int DATA_W    = 10;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 64;
  localparam int STEP_W    = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lstm_x_feeder_if #(.DATA_W(DATA_W), .STEP_W(STEP_W)) bus ();

  lstm_x_feeder #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .DEPTH(DEPTH), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] q[$];
  bit ovf_m = 1'b0;
  bit wr_burst = 1'b0;
  bit sd_mid = 1'b0;
  logic [DATA_W-1:0] vec [8] = '{10'h3E7, 10'h381, 10'h307, 10'h043,
                                 10'h002, 10'h026, 10'h3E1, 10'h342};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (q.size() < DEPTH) q.push_back(d);
    else ovf_m = 1'b1;
  endtask

  task automatic write(input logic [DATA_W-1:0] d);
    push_sample(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.step_done = 1'b0;
    tick();
    reset = 1'b1;
    q.delete();
    ovf_m = 1'b0;
  endtask

  // Trigger (start, step_done or last write) is already driven at this negedge.
  task automatic expect_burst(input int k);
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.start = 1'b0; bus.step_done = 1'b0; bus.wr_en = 1'b0;
      check("lead_load", 32'(bus.load), 32'(0));
      check("lead_x", 32'(bus.x_out), 32'(0));
      check("lead_busy", 32'(bus.busy), 32'(1));
      check("lead_step_cnt", 32'(bus.step_cnt), 32'(k));
    end
    for (int i = 0; i < BURST_LEN; i++) begin
      if (wr_burst) push_sample(DATA_W'($urandom));
      if (sd_mid && i == 3) bus.step_done = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      exp = q.pop_front();
      check("burst_load", 32'(bus.load), 32'(1));
      check("burst_x", 32'(bus.x_out), 32'(exp));
    end
    tick();
    check("post_load", 32'(bus.load), 32'(0));
    check("post_x", 32'(bus.x_out), 32'(0));
  endtask

  task automatic run_seq(input int n);
    bus.num_steps = STEP_W'(n);
    bus.start = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) bus.step_done = 1'b1;
      if (q.size() >= BURST_LEN) begin
        expect_burst(k);
      end else begin
        for (int i = 0; i < 3; i++) begin
          tick();
          bus.start = 1'b0; bus.step_done = 1'b0;
          check("stall_load", 32'(bus.load), 32'(0));
          check("stall_busy", 32'(bus.busy), 32'(1));
          check("stall_step_cnt", 32'(bus.step_cnt), 32'(k));
        end
        while (q.size() < BURST_LEN - 1) write(DATA_W'($urandom));
        push_sample(DATA_W'($urandom));
        expect_burst(k);
      end
    end
    bus.step_done = 1'b1;
    tick();
    bus.step_done = 1'b0;
    check("seq_done_hi", 32'(bus.seq_done), 32'(1));
    check("final_step_cnt", 32'(bus.step_cnt), 32'(n));
    check("done_busy", 32'(bus.busy), 32'(0));
    tick();
    check("seq_done_lo", 32'(bus.seq_done), 32'(0));
    check("hold_step_cnt", 32'(bus.step_cnt), 32'(n));
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0;
    bus.num_steps = '0; bus.step_done = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_load", 32'(bus.load), 32'(0));
    check("rst_x", 32'(bus.x_out), 32'(0));
    check("rst_full", 32'(bus.full), 32'(0));
    check("rst_ovf", 32'(bus.overflow), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_seq_done", 32'(bus.seq_done), 32'(0));
    check("rst_step_cnt", 32'(bus.step_cnt), 32'(0));
    reset = 1'b1;
    tick();

    // Single step with fixed samples
    for (int i = 0; i < 8; i++) write(vec[i]);
    run_seq(1);

    // Zero-step sequence
    bus.num_steps = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_seq_done", 32'(bus.seq_done), 32'(1));
    check("zero_busy", 32'(bus.busy), 32'(0));
    check("zero_step_cnt", 32'(bus.step_cnt), 32'(0));
    tick();
    check("zero_seq_done_lo", 32'(bus.seq_done), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_load", 32'(bus.load), 32'(0));
    end

    // Starve: 12 samples for two steps, remainder written during the stall
    for (int i = 0; i < 12; i++) write(DATA_W'($urandom));
    run_seq(2);

    // Handshake: level held across the burst end, start while busy
    for (int i = 0; i < 8; i++) write(DATA_W'($urandom));
    bus.num_steps = STEP_W'(1);
    bus.start = 1'b1;
    sd_mid = 1'b1;
    expect_burst(0);
    sd_mid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hs_no_ack", 32'(bus.step_cnt), 32'(0));
      check("hs_no_done", 32'(bus.seq_done), 32'(0));
      check("hs_busy", 32'(bus.busy), 32'(1));
    end
    bus.num_steps = STEP_W'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("hs_start_ign_busy", 32'(bus.busy), 32'(1));
    check("hs_start_ign_cnt", 32'(bus.step_cnt), 32'(0));
    bus.step_done = 1'b0;
    tick();
    bus.step_done = 1'b1;
    tick();
    check("hs_ack_done", 32'(bus.seq_done), 32'(1));
    check("hs_ack_cnt", 32'(bus.step_cnt), 32'(1));
    tick();
    check("hs_ack_once", 32'(bus.step_cnt), 32'(1));
    check("hs_done_lo", 32'(bus.seq_done), 32'(0));
    bus.step_done = 1'b0;

    // Asynchronous reset in the middle of the second burst
    do_reset();
    for (int i = 0; i < 16; i++) write(DATA_W'($urandom));
    wr_burst = 1'b0;
    bus.num_steps = STEP_W'(2);
    bus.start = 1'b1;
    expect_burst(0);
    bus.step_done = 1'b1;
    tick(); bus.step_done = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      logic [DATA_W-1:0] e;
      tick();
      e = q.pop_front();
      check("mid_load", 32'(bus.load), 32'(1));
      check("mid_x", 32'(bus.x_out), 32'(e));
    end
    check("mid_step_cnt", 32'(bus.step_cnt), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("async_load", 32'(bus.load), 32'(0));
    check("async_x", 32'(bus.x_out), 32'(0));
    check("async_busy", 32'(bus.busy), 32'(0));
    check("async_step_cnt", 32'(bus.step_cnt), 32'(0));
    tick();
    reset = 1'b1;
    q.delete();
    ovf_m = 1'b0;
    run_seq(1);

    // Full/overflow and concurrent write+read
    do_reset();
    for (int i = 0; i < 20; i++) write(DATA_W'($urandom));
    wr_burst = 1'b1;
    run_seq(1);
    wr_burst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      write(DATA_W'($urandom));
      check("fill_full", 32'(bus.full), 32'(q.size() == DEPTH));
      check("fill_ovf", 32'(bus.overflow), 32'(ovf_m));
    end
    tick();
    check("ovf_sticky", 32'(bus.overflow), 32'(1));
    run_seq(2);
    check("not_full", 32'(bus.full), 32'(0));

    // Random sequences
    do_reset();
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 12)) write(DATA_W'($urandom));
      wr_burst = ($urandom_range(0, 1) == 1);
      run_seq(int'($urandom_range(1, 3)));
    end
    wr_burst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
